// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter and the VGA fetcher that talks to it.
// Holds the RAM geometry and the grant encoding used on both sides of the port.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_CPU  = 2'd1,
        GRANT_VGA  = 2'd2
    } grant_t;

endpackage

// File: rtl/dmem_arbiter_blank_window_timer.sv
// Opens a VGA-priority window of BLANK_CYCLES clocks after each screen_end pulse.
// A pulse during an open window restarts the count rather than extending it.
module blank_window_timer
    import dmem_arbiter_pkg::*;
#(
    parameter int BLANK_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic screen_end,
    output logic in_blank
);

    localparam int CTR_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    logic [CTR_W-1:0] blank_ctr;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from before the edge; blocking here would create ordering races.
    always_ff @(posedge clock) begin
        if (!reset) begin
            blank_ctr <= '0;
            in_blank  <= 1'b0;
        end else if (screen_end) begin
            blank_ctr <= CTR_W'(BLANK_CYCLES - 1);
            in_blank  <= 1'b1;
        end else if (in_blank) begin
            // The cycle with blank_ctr==0 is the last one inside the window.
            if (blank_ctr == '0) begin
                in_blank <= 1'b0;
            end else begin
                blank_ctr <= blank_ctr - CTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the processor and the VGA fetcher.
// CPU wins by default; VGA wins inside the blanking window or once it has starved.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int MAX_WAIT     = 8,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              screen_end,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_q,
    output logic              in_blank,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    localparam int WAIT_W = $clog2(MAX_WAIT);

    grant_t              grant;
    logic [WAIT_W-1:0]   wait_ctr;
    logic                wait_full;
    logic [DATA_W-1:0]   vga_q_hold;

    blank_window_timer #(
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_blank_timer (
        .clock      (clock),
        .reset      (reset),
        .screen_end (screen_end),
        .in_blank   (in_blank)
    );

    assign wait_full = (wait_ctr == WAIT_W'(MAX_WAIT - 1));

    // NOTE: grant gets a default before any branch so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        grant = GRANT_NONE;
        if (cpu_req && vga_req) begin
            grant = (in_blank || wait_full) ? GRANT_VGA : GRANT_CPU;
        end else if (cpu_req) begin
            grant = GRANT_CPU;
        end else if (vga_req) begin
            grant = GRANT_VGA;
        end
    end

    assign vga_ack    = (grant == GRANT_VGA);
    assign cpu_stall  = cpu_req & vga_ack;
    assign ram_wEn    = cpu_req & cpu_wren & (grant == GRANT_CPU);
    assign ram_addr   = vga_ack ? vga_addr : cpu_addr;
    assign ram_dataIn = cpu_data;
    assign cpu_q      = ram_dataOut;

    // Counts consecutive lost cycles; inside the window VGA never loses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_ctr <= '0;
        end else if (vga_req && !vga_ack && !in_blank) begin
            if (!wait_full) begin
                wait_ctr <= wait_ctr + WAIT_W'(1);
            end
        end else begin
            wait_ctr <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vga_rvalid <= 1'b0;
            vga_q_hold <= '0;
        end else begin
            vga_rvalid <= vga_ack;
            if (vga_rvalid) begin
                vga_q_hold <= ram_dataOut;
            end
        end
    end

    // The RAM read arrives in the rvalid cycle itself; outside it the last value holds.
    assign vga_q = vga_rvalid ? ram_dataOut : vga_q_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle model predicts grants and read data,
// a negedge monitor compares them against the DUT and a behavioural RAM.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW       = 12;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 8;
    localparam int BLANK    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          screen_end = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_wren = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic [DW-1:0] cpu_q;
    logic          cpu_stall;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_ack;
    logic          vga_rvalid;
    logic [DW-1:0] vga_q;
    logic          in_blank;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .BLANK_CYCLES(BLANK)
    ) dut (
        .clock(clock), .reset(reset), .screen_end(screen_end),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_q(cpu_q), .cpu_stall(cpu_stall),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
        .vga_rvalid(vga_rvalid), .vga_q(vga_q), .in_blank(in_blank),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 32'h020) ? 32'h1234_5678 : (32'h0BAD_0000 | a);
    endfunction

    // Behavioural single-port RAM with registered read (old data on same-address write).
    logic [DW-1:0] ram [0:4095];
    logic          ram_loaded = 1'b0;
    int            wr30 = 0;
    always @(posedge clock) begin
        logic [DW-1:0] rd;
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
            ram_loaded = 1'b1;
        end
        rd = ram[ram_addr];
        if (ram_wEn) begin
            ram[ram_addr] = ram_dataIn;
            if (ram_addr == 12'h030) wr30 <= wr30 + 1;
        end
        ram_dataOut <= rd;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          in_blank;
        logic          vga_ack;
        logic          cpu_stall;
        logic          ram_wEn;
        logic [AW-1:0] ram_addr;
        logic [DW-1:0] ram_dataIn;
        logic          rvalid;
        logic          clr_hold;
        logic          cpu_chk;
        logic [DW-1:0] cpu_q;
    } exp_t;

    exp_t          cyc_q[$];
    logic [DW-1:0] vga_exp_q[$];

    // Reference model state, expressed as spec-level quantities.
    logic [DW-1:0] gold [0:4095];
    int            blank_left = 0;     // window cycles still to come, including this one
    int            lost = 0;           // consecutive cycles VGA has lost
    logic          prev_rv = 1'b0;
    logic          prev_rst = 1'b1;    // reset was asserted at time 0
    logic          prev_cpu_rd = 1'b0;
    logic [DW-1:0] prev_cpu_data = '0;
    logic          last_gv = 1'b0;
    logic          last_gc = 1'b0;

    task automatic step(input logic rst, input logic se, input logic creq, input logic cwr,
                        input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic vreq, input logic [AW-1:0] va);
        exp_t e;
        logic gv, gc, inb;
        @(posedge clock);
        #1;
        reset = rst; screen_end = se; cpu_req = creq; cpu_wren = cwr;
        cpu_addr = ca; cpu_data = cd; vga_req = vreq; vga_addr = va;

        inb = (blank_left > 0);
        gv  = vreq && (!creq || inb || lost == MAX_WAIT - 1);
        gc  = creq && !gv;

        e.in_blank   = inb;
        e.vga_ack    = gv;
        e.cpu_stall  = creq && gv;
        e.ram_wEn    = gc && cwr;
        e.ram_addr   = gv ? va : ca;
        e.ram_dataIn = cd;
        e.rvalid     = prev_rv;
        e.clr_hold   = prev_rst;
        e.cpu_chk    = prev_cpu_rd;
        e.cpu_q      = prev_cpu_data;
        cyc_q.push_back(e);

        prev_rv = gv && rst;
        if (prev_rv) vga_exp_q.push_back(gold[va]);
        prev_cpu_rd   = gc && !cwr;
        prev_cpu_data = gold[ca];
        if (gc && cwr) gold[ca] = cd;
        prev_rst = !rst;
        last_gv  = gv;
        last_gc  = gc;

        if (!rst) begin
            blank_left = 0;
            lost       = 0;
        end else begin
            if (se) blank_left = BLANK;
            else if (blank_left > 0) blank_left--;
            lost = (vreq && !gv) ? ((lost + 1 > MAX_WAIT - 1) ? MAX_WAIT - 1 : lost + 1) : 0;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
    endtask

    // Monitor: pops one cycle record per clock and a read result per vga_rvalid.
    logic [DW-1:0] held = '0;
    initial begin
        exp_t e;
        logic [DW-1:0] vexp;
        forever begin
            @(negedge clock);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("in_blank",   in_blank,   e.in_blank);
                check("vga_ack",    vga_ack,    e.vga_ack);
                check("cpu_stall",  cpu_stall,  e.cpu_stall);
                check("ram_wEn",    ram_wEn,    e.ram_wEn);
                check("ram_addr",   ram_addr,   e.ram_addr);
                check("ram_dataIn", ram_dataIn, e.ram_dataIn);
                check("vga_rvalid", vga_rvalid, e.rvalid);
                if (e.clr_hold) held = '0;
                if (vga_rvalid === 1'b1) begin
                    if (vga_exp_q.size() == 0) begin
                        check("vga_rvalid_unexpected", 1'b1, 1'b0);
                    end else begin
                        vexp = vga_exp_q.pop_front();
                        held = vexp;
                    end
                end
                check("vga_q", vga_q, held);
                if (e.cpu_chk) check("cpu_q", cpu_q, e.cpu_q);
            end
        end
    end

    initial begin
        int guard;
        logic creq, cwr, vreq, se, rst;
        logic [AW-1:0] ca, va;
        logic [DW-1:0] cd;

        for (int i = 0; i < 4096; i++) gold[i] = init_word(i);

        // Reset held with both requesting, then the first open cycle goes to the CPU.
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h100, 32'h0, 1'b1, 12'h101);
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h100, 32'h0, 1'b1, 12'h101);
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h100, 32'h0, 1'b1, 12'h101);
        idle();

        // CPU store, read-back, and a VGA-only read.
        step(1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, 12'h000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h000);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h020);
        idle();

        // Continuous contention outside the window: starvation forces VGA through.
        va = 12'h040;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, AW'(i), 32'h0, 1'b1, va);
            if (last_gv) va = va + 12'h001;
        end
        idle();

        // Blank window with a restart two cycles in.
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h005, 32'h0, 1'b1, 12'h050);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 1), 1'b1, 1'b0, 12'h006, 32'h0, 1'b1, AW'(12'h051 + i));
        end
        idle();

        // CPU store stalled by the window: written exactly once afterwards.
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h060);
        guard = 0;
        do begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 12'h030, 32'hCAFE_F00D, 1'b1, AW'(12'h061 + guard));
            guard++;
        end while (!last_gc && guard < 20);
        check("stalled_store_granted", last_gc, 1'b1);
        idle();
        idle();
        check("store_write_count", wr30, 1);
        check("store_ram_value", ram[12'h030], 32'hCAFE_F00D);

        // Randomised traffic with occasional frame pulses and resets.
        creq = 1'b0; cwr = 1'b0; ca = '0; cd = '0; vreq = 1'b0; va = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!(cpu_req && !last_gc)) begin
                creq = ($urandom_range(3) != 0);
                cwr  = $urandom_range(1) == 1;
                ca   = AW'($urandom_range(63));
                cd   = $urandom;
            end
            if (!(vga_req && !last_gv)) begin
                vreq = $urandom_range(1) == 1;
                va   = AW'($urandom_range(63));
            end
            se  = ($urandom_range(99) == 0);
            rst = ($urandom_range(299) != 0);
            step(rst, se, creq, cwr, ca, cd, vreq, va);
        end
        idle();
        idle();
        @(negedge clock);
        #1;

        check("vga_reads_drained", vga_exp_q.size(), 0);
        for (int a = 0; a < 64; a++) check("final_ram", ram[a], gold[a]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data RAM (12-bit address, 32-bit words, registered read) between the processor and the VGA sprite/obstacle fetcher.
- The processor owns the port by default.
- The VGA side gets guaranteed bandwidth two ways: a per-frame blanking window that opens after each screen_end pulse, and a starvation counter outside that window.
- Sits between processor/VGAController and the RAM instance in the top-level wrapper.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 32, RAM data width
MAX_WAIT, 8, consecutive lost cycles after which a waiting VGA request is forced through (>=2)
BLANK_CYCLES, 1024, length in clocks of the VGA-priority window after screen_end (>=1)

Ports:
clock  input  1  system clock; all state on posedge
reset  input  1  synchronous, active-low reset
screen_end  input  1  one-cycle pulse at end of visible frame (60 Hz)
cpu_req  input  1  processor memory access this cycle (load or store)
cpu_wren  input  1  store when high; ignored unless cpu_req
cpu_addr  input  ADDR_W  processor address
cpu_data  input  DATA_W  processor store data
cpu_q  output  DATA_W  read data to processor
cpu_stall  output  1  processor lost arbitration this cycle; it must hold its request
vga_req  input  1  VGA read request; held with vga_addr until vga_ack
vga_addr  input  ADDR_W  VGA read address
vga_ack  output  1  VGA request granted this cycle
vga_rvalid  output  1  vga_q valid (one cycle after vga_ack)
vga_q  output  DATA_W  read data to VGA
in_blank  output  1  blanking window active
ram_wEn  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_dataIn  output  DATA_W  RAM write data
ram_dataOut  input  DATA_W  RAM registered read data

Behaviour:
- Reset (reset==0 at a posedge): blank_ctr=0, in_blank=0, wait_ctr=0, vga_rvalid=0, vga_q=0.
- Reset value of combinational outputs: cpu_stall, vga_ack and ram_wEn are low whenever the requests are low. Reset overrides screen_end in the same cycle.
- Blank window:
  - screen_end loads blank_ctr=BLANK_CYCLES-1 and sets in_blank.
  - Each later cycle decrements blank_ctr; in_blank clears on the cycle after blank_ctr reaches 0.
  - screen_end during an active window reloads the counter (restart; no accumulation).
- Grant, combinational in each cycle:
  - Only cpu_req: CPU granted.
  - Only vga_req: VGA granted.
  - Both, in_blank=1: VGA granted.
  - Both, in_blank=0, wait_ctr==MAX_WAIT-1: VGA granted.
  - Both, otherwise: CPU granted.
  - Neither: no grant, ram_wEn=0, ram_addr=cpu_addr.
- Outputs from the grant:
  - vga_ack=1 exactly when VGA is granted.
  - cpu_stall = cpu_req & VGA granted.
  - ram_addr follows the granted requester.
  - ram_wEn = cpu_wren & cpu_req & CPU granted.
  - ram_dataIn = cpu_data always.
- wait_ctr:
  - Increments when vga_req is high and VGA is not granted.
  - Clears on any VGA grant, or when vga_req is low.
  - Saturates at MAX_WAIT-1.
  - Not incremented while in_blank, since VGA cannot lose then.
- Read return:
  - vga_rvalid is a registered copy of vga_ack.
  - When vga_rvalid=1, vga_q = ram_dataOut; otherwise vga_q holds its last value.
  - cpu_q = ram_dataOut unconditionally. Processor load latency is unchanged: data arrives one cycle after an un-stalled cycle.
- Back-to-back VGA grants pipeline: acks on consecutive cycles produce rvalid on consecutive cycles.
- Stores never drop:
  - A stalled CPU store produces no RAM write in the stalled cycle.
  - It is written on the first granted cycle.
- Reset mid-window or mid-read: the window aborts, and an in-flight vga_rvalid is suppressed (0 on the cycle after reset).

Decomposition:
- Shared package: ADDR_W/DATA_W constants and a grant encoding (GRANT_NONE, GRANT_CPU, GRANT_VGA), reused by the VGA fetcher.
- One sub-module is natural: blank_window_timer (screen_end in; in_blank out; BLANK_CYCLES parameter).
- Grant logic and wait_ctr stay in the top module.

Test Plan:
- Reset low 2 cycles with cpu_req=vga_req=1 -> after release vga_rvalid=0, in_blank=0, wait_ctr=0; first cycle outside blank grants CPU (cpu_stall=0, vga_ack=0).
- cpu_req=1 cpu_wren=1 addr=0x010 data=0xDEADBEEF, no VGA -> ram_wEn=1, ram_addr=0x010. Next cycle read of 0x010 -> cpu_q=0xDEADBEEF one cycle later.
- VGA only, vga_addr=0x020 (RAM holds 0x12345678) -> vga_ack same cycle; vga_rvalid=1 and vga_q=0x12345678 next cycle.
- Both requesting continuously, in_blank=0, MAX_WAIT=8 -> CPU granted 7 cycles, VGA granted on the 8th (cpu_stall=1 that cycle), then pattern repeats.
- screen_end pulse with BLANK_CYCLES=4, both requesting -> vga_ack=1 and cpu_stall=1 for 4 cycles, CPU granted on 5th; second screen_end at cycle 2 extends the window to 4 cycles from the reload.
- Stalled CPU store (in_blank, store to 0x030) -> ram_wEn=0 while stalled; exactly one write of cpu_data to 0x030 when granted after the window ends.
